// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a simple dual-port RAM with a
// one-cycle registered read; a 2-entry output buffer hides that read latency.
module ram_fifo_ctrl #(
    parameter int MEMORY_WIDTH = 72,
    parameter int ADDRS_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    s_valid_i,
    input  logic [MEMORY_WIDTH-1:0] s_data_i,
    output logic                    s_ready_o,
    output logic                    m_valid_o,
    output logic [MEMORY_WIDTH-1:0] m_data_o,
    input  logic                    m_ready_i,
    output logic [ADDRS_WIDTH:0]    ram_level_o,
    output logic                    ram_ena_o,
    output logic                    ram_wea_o,
    output logic [ADDRS_WIDTH-1:0]  ram_addra_o,
    output logic [MEMORY_WIDTH-1:0] ram_dia_o,
    output logic                    ram_enb_o,
    output logic [ADDRS_WIDTH-1:0]  ram_addrb_o,
    input  logic [MEMORY_WIDTH-1:0] ram_dob_i
);

    localparam logic [ADDRS_WIDTH:0] FULL_LEVEL = {1'b1, {ADDRS_WIDTH{1'b0}}};

    logic [ADDRS_WIDTH:0]    wr_ptr;
    logic [ADDRS_WIDTH:0]    rd_ptr;
    logic                    rd_pend;
    logic [1:0]              out_cnt;
    logic [MEMORY_WIDTH-1:0] obuf0;
    logic [MEMORY_WIDTH-1:0] obuf1;

    logic                    push;
    logic                    pop;
    logic                    issue;
    logic [2:0]              occ_next;
    logic [1:0]              cnt_after_pop;
    logic [1:0]              cnt_next;
    logic [MEMORY_WIDTH-1:0] obuf0_next;
    logic [MEMORY_WIDTH-1:0] obuf1_next;

    // Level and ready come from registered pointers only: a word written this
    // cycle is not readable until the next, avoiding RAM read/write collisions.
    assign ram_level_o = wr_ptr - rd_ptr;
    assign s_ready_o   = (ram_level_o != FULL_LEVEL);
    assign m_valid_o   = (out_cnt != 2'd0);
    assign m_data_o    = obuf0;

    assign push = s_valid_i & s_ready_o;
    assign pop  = m_valid_o & m_ready_i;

    // Port A: write path, combinational from the producer handshake
    assign ram_ena_o   = push;
    assign ram_wea_o   = push;
    assign ram_addra_o = wr_ptr[ADDRS_WIDTH-1:0];
    assign ram_dia_o   = s_data_i;

    // Port B: only issue a read when its word is guaranteed a buffer slot
    assign occ_next    = {1'b0, out_cnt} + {2'b00, rd_pend} + 3'd1 - {2'b00, pop};
    assign issue       = (ram_level_o != '0) & (occ_next <= 3'd2);
    assign ram_enb_o   = issue;
    assign ram_addrb_o = rd_ptr[ADDRS_WIDTH-1:0];

    // Output buffer: shift on pop, then append the landing read word behind it
    assign cnt_after_pop = out_cnt - {1'b0, pop};
    assign cnt_next      = cnt_after_pop + {1'b0, rd_pend};

    always_comb begin
        obuf0_next = pop ? obuf1 : obuf0;
        obuf1_next = obuf1;
        if (rd_pend) begin
            if (cnt_after_pop == 2'd0) begin
                obuf0_next = ram_dob_i;
            end else begin
                obuf1_next = ram_dob_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_pend <= 1'b0;
            out_cnt <= 2'd0;
            obuf0   <= '0;
            obuf1   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_pend <= issue;
            out_cnt <= cnt_next;
            obuf0   <= obuf0_next;
            obuf1   <= obuf1_next;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (DEPTH 8, 16-bit words) with a behavioural
// registered-read dual-port RAM attached to the controller's RAM ports.
module tb_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic [3:0]  ram_level;
    logic        ram_ena;
    logic        ram_wea;
    logic [2:0]  ram_addra;
    logic [15:0] ram_dia;
    logic        ram_enb;
    logic [2:0]  ram_addrb;
    logic [15:0] ram_dob;

    logic [15:0] mem [8];

    int n_cmp = 0;
    int n_bad = 0;

    ram_fifo_ctrl #(.MEMORY_WIDTH(16), .ADDRS_WIDTH(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready),
        .ram_level_o(ram_level),
        .ram_ena_o(ram_ena), .ram_wea_o(ram_wea), .ram_addra_o(ram_addra), .ram_dia_o(ram_dia),
        .ram_enb_o(ram_enb), .ram_addrb_o(ram_addrb), .ram_dob_i(ram_dob)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 16'h0) begin n_bad++; $display("FAIL reset_m_data got %h want 0000", m_data); end
        n_cmp++; if (ram_level !== 4'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", ram_level); end
        n_cmp++; if ({ram_ena, ram_wea, ram_enb} !== 3'b000) begin n_bad++; $display("FAIL reset_enables got %b want 000", {ram_ena, ram_wea, ram_enb}); end
    endtask

    task automatic test_single_word();
        do_reset();
        s_valid = 1'b1; s_data = 16'hA5A5; #1;
        n_cmp++; if ({ram_ena, ram_wea, ram_addra, ram_dia} !== {2'b11, 3'd0, 16'hA5A5}) begin
            n_bad++; $display("FAIL single_write_port got %b%b %0d %h want 11 0 a5a5", ram_ena, ram_wea, ram_addra, ram_dia); end
        n_cmp++; if (ram_enb !== 1'b0) begin n_bad++; $display("FAIL single_no_early_read got %b want 0", ram_enb); end
        step(); s_valid = 1'b0; #1;
        n_cmp++; if ({ram_enb, ram_addrb, m_valid} !== {1'b1, 3'd0, 1'b0}) begin
            n_bad++; $display("FAIL single_cycle1 enb %b addrb %0d m_valid %b want 1 0 0", ram_enb, ram_addrb, m_valid); end
        step();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_cycle2_valid got %b want 0", m_valid); end
        step();
        n_cmp++; if ({m_valid, m_data} !== {1'b1, 16'hA5A5}) begin
            n_bad++; $display("FAIL single_cycle3 got %b %h want 1 a5a5", m_valid, m_data); end
        m_ready = 1'b1;
        step(); m_ready = 1'b0;
        n_cmp++; if ({m_valid, ram_level} !== {1'b0, 4'd0}) begin
            n_bad++; $display("FAIL single_after_pop valid %b level %0d want 0 0", m_valid, ram_level); end
    endtask

    task automatic test_fill_stall();
        int got = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 16'(i); #1;
            n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_%0d got %b want 1", i, s_ready); end
            step();
        end
        s_data = 16'hDEAD; #1;
        n_cmp++; if ({s_ready, ram_ena} !== 2'b00) begin n_bad++; $display("FAIL fill_full_ready got %b ena %b want 0 0", s_ready, ram_ena); end
        n_cmp++; if (ram_level !== 4'd8) begin n_bad++; $display("FAIL fill_level got %0d want 8", ram_level); end
        n_cmp++; if (dut.out_cnt !== 2'd2) begin n_bad++; $display("FAIL fill_out_cnt got %0d want 2", dut.out_cnt); end
        step(); step();
        n_cmp++; if ({s_ready, ram_level} !== {1'b0, 4'd8}) begin n_bad++; $display("FAIL fill_hold ready %b level %0d want 0 8", s_ready, ram_level); end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 60 && got < 10; c++) begin
            if (m_valid) begin
                n_cmp++; if (m_data !== 16'(got)) begin n_bad++; $display("FAIL fill_drain_%0d got %h want %h", got, m_data, 16'(got)); end
                got++;
            end
            step();
        end
        m_ready = 1'b0;
        n_cmp++; if (got !== 10) begin n_bad++; $display("FAIL fill_drain_count got %0d want 10", got); end
        n_cmp++; if ({m_valid, ram_level} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL fill_empty valid %b level %0d want 0 0", m_valid, ram_level); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 106; c++) begin
            s_valid = (c < 100); s_data = 16'(c); #1;
            if (c < 100) begin
                n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_c%0d got %b want 1", c, s_ready); end
            end
            n_cmp++; if (m_valid !== (c >= 3 && c < 103)) begin n_bad++; $display("FAIL b2b_valid_c%0d got %b want %b", c, m_valid, (c >= 3 && c < 103)); end
            if (c >= 3 && c < 103) begin
                n_cmp++; if (m_data !== 16'(c - 3)) begin n_bad++; $display("FAIL b2b_data_c%0d got %h want %h", c, m_data, 16'(c - 3)); end
            end
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        int sent = 0;
        int recv = 0;
        bit  p, w;
        do_reset();
        for (int c = 0; c < 20000 && recv < 1000; c++) begin
            s_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            s_data  = 16'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            #1;
            w = s_valid && s_ready;
            p = m_valid && m_ready;
            if (ram_level > 4'd8 || (ram_ena && ram_level == 4'd8)) begin
                n_cmp++; n_bad++; $display("FAIL rand_overflow level %0d ena %b want <=8 and no write when full", ram_level, ram_ena);
            end
            if (p) begin
                n_cmp++;
                if (q.size() == 0) begin n_bad++; $display("FAIL rand_spurious got %h want none", m_data); end
                else if (m_data !== q[0]) begin n_bad++; $display("FAIL rand_order_%0d got %h want %h", recv, m_data, q[0]); end
                if (q.size() != 0) void'(q.pop_front());
                recv++;
            end
            if (w) begin q.push_back(s_data); sent++; end
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0; #1;
        n_cmp++; if (recv !== 1000) begin n_bad++; $display("FAIL rand_count got %0d want 1000", recv); end
        n_cmp++; if ({ram_level, m_valid} !== {4'd0, 1'b0}) begin n_bad++; $display("FAIL rand_drained level %0d valid %b want 0 0", ram_level, m_valid); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 16'h0E00 + 16'(i);
            step();
        end
        // Here one word sits in the buffer and another read is in flight.
        s_valid = 1'b0; rst = 1'b1; #1;
        n_cmp++; if ({dut.out_cnt, dut.rd_pend} !== {2'd1, 1'b1}) begin n_bad++; $display("FAIL rst_pre_state cnt %0d pend %b want 1 1", dut.out_cnt, dut.rd_pend); end
        step(); rst = 1'b0; #1;
        n_cmp++; if ({m_valid, ram_level, s_ready, m_data} !== {1'b0, 4'd0, 1'b1, 16'h0}) begin
            n_bad++; $display("FAIL rst_inflight valid %b level %0d ready %b data %h want 0 0 1 0000", m_valid, ram_level, s_ready, m_data); end
        s_valid = 1'b1; s_data = 16'h1234;
        step(); s_valid = 1'b0;
        step();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stale_word got %b want 0", m_valid); end
        step();
        n_cmp++; if ({m_valid, m_data} !== {1'b1, 16'h1234}) begin n_bad++; $display("FAIL rst_new_word got %b %h want 1 1234", m_valid, m_data); end
        m_ready = 1'b1;
        step(); m_ready = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_word_alone got %b want 0", m_valid); end
    endtask

    task automatic test_full_single_pop();
        int got = 0;
        logic [15:0] exp;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 16'h0100 + 16'(i);
            step();
        end
        s_data = 16'hBEEF; #1;
        n_cmp++; if ({s_ready, ram_ena} !== 2'b00) begin n_bad++; $display("FAIL full_blocked ready %b ena %b want 0 0", s_ready, ram_ena); end
        m_ready = 1'b1; #1;
        n_cmp++; if ({ram_enb, ram_ena, m_data} !== {2'b10, 16'h0100}) begin
            n_bad++; $display("FAIL full_pop_cycle enb %b ena %b data %h want 1 0 0100", ram_enb, ram_ena, m_data); end
        step(); m_ready = 1'b0; #1;
        n_cmp++; if ({s_ready, ram_ena, ram_addra} !== {2'b11, 3'd2}) begin
            n_bad++; $display("FAIL full_one_write ready %b ena %b addr %0d want 1 1 2", s_ready, ram_ena, ram_addra); end
        step();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if ({s_ready, ram_ena} !== 2'b00) begin n_bad++; $display("FAIL full_no_second_write_%0d ready %b ena %b want 0 0", k, s_ready, ram_ena); end
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 60 && got < 10; c++) begin
            if (m_valid) begin
                exp = (got < 9) ? 16'h0101 + 16'(got) : 16'hBEEF;
                n_cmp++; if (m_data !== exp) begin n_bad++; $display("FAIL full_drain_%0d got %h want %h", got, m_data, exp); end
                got++;
            end
            step();
        end
        m_ready = 1'b0;
        n_cmp++; if ({got, m_valid} !== {32'd10, 1'b0}) begin n_bad++; $display("FAIL full_drain_count got %0d valid %b want 10 0", got, m_valid); end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        test_reset();
        test_single_word();
        test_fill_stall();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        test_full_single_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
